// File: rtl/fpm_result_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fpm_result_collector                                          |
// | Purpose  : Classifies FP multiplier products, buffers them in a FWFT     |
// |            FIFO and keeps saturating flag statistics.                    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module fpm_result_collector #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [31:0]              fp_Z,
    input  logic                     ovrf,
    input  logic                     udrf,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_z,
    output logic [2:0]               out_class,
    output logic                     out_ovrf,
    output logic                     out_udrf,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    input  logic                     clr_stats,
    output logic [CNT_W-1:0]         ovrf_cnt,
    output logic [CNT_W-1:0]         udrf_cnt,
    output logic [CNT_W-1:0]         nan_cnt,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int                  c_ADDR_W = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0]   c_FULL   = (c_ADDR_W + 1)'(DEPTH);
    localparam logic [2:0]          c_ZERO   = 3'd0;
    localparam logic [2:0]          c_SUB    = 3'd1;
    localparam logic [2:0]          c_NORM   = 3'd2;
    localparam logic [2:0]          c_INF    = 3'd3;
    localparam logic [2:0]          c_NAN    = 3'd4;

    logic [31:0]         r_mem_z   [DEPTH];
    logic [2:0]          r_mem_cls [DEPTH];
    logic                r_mem_ov  [DEPTH];
    logic                r_mem_ud  [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;
    logic [CNT_W-1:0]    r_ovrf_cnt;
    logic [CNT_W-1:0]    r_udrf_cnt;
    logic [CNT_W-1:0]    r_nan_cnt;
    logic [CNT_W-1:0]    r_drop_cnt;

    logic [2:0]          w_class;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    always_comb begin
        w_class = c_NORM;
        if (fp_Z[30:23] == 8'd0)
            w_class = (fp_Z[22:0] == 23'd0) ? c_ZERO : c_SUB;
        else if (fp_Z[30:23] == 8'hFF)
            w_class = (fp_Z[22:0] == 23'd0) ? c_INF : c_NAN;
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);
    assign w_pop   = !w_empty && out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push  = in_valid && (!w_full || w_pop);
    assign w_drop  = in_valid && w_full && !w_pop;

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem_z[r_wr_ptr]   <= fp_Z;
            r_mem_cls[r_wr_ptr] <= w_class;
            r_mem_ov[r_wr_ptr]  <= ovrf;
            r_mem_ud[r_wr_ptr]  <= udrf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Clear wins over any increment landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            r_ovrf_cnt <= '0;
            r_udrf_cnt <= '0;
            r_nan_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_ovrf_cnt <= f_sat_inc(r_ovrf_cnt, w_push && ovrf);
            r_udrf_cnt <= f_sat_inc(r_udrf_cnt, w_push && udrf);
            r_nan_cnt  <= f_sat_inc(r_nan_cnt, w_push && (w_class == c_NAN));
            r_drop_cnt <= f_sat_inc(r_drop_cnt, w_drop);
        end
    end

    assign out_valid = !w_empty;
    assign out_z     = w_empty ? 32'd0 : r_mem_z[r_rd_ptr];
    assign out_class = w_empty ? 3'd0  : r_mem_cls[r_rd_ptr];
    assign out_ovrf  = w_empty ? 1'b0  : r_mem_ov[r_rd_ptr];
    assign out_udrf  = w_empty ? 1'b0  : r_mem_ud[r_rd_ptr];
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign ovrf_cnt  = r_ovrf_cnt;
    assign udrf_cnt  = r_udrf_cnt;
    assign nan_cnt   = r_nan_cnt;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire
